depth_fifo: RTL and testbench

DEPTH_FIFO -- requirements
Module: depth_fifo

---
 rtl/depth_fifo.sv | 73 +++++++
 tb/tb_depth_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/depth_fifo.sv
// Synchronous FIFO with a valid/ready handshake on both sides, occupancy count and
// almost-full flag. A full FIFO still accepts a write when a read happens in the same cycle.
module depth_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     almost_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] COUNT_STEP = CW'(1);
  localparam logic [PW-1:0] PTR_STEP   = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             active;
  logic             push;
  logic             pop;

  // Reset and flush both block the handshake so that nothing is written or consumed
  // in a cycle whose state is about to be cleared.
  assign active  = reset_n_i & ~flush_i;
  assign valid_o = (count != '0);
  assign ready_o = active & ((count != FULL_COUNT) | ready_i);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i & active;

  assign data_o        = mem[rd_ptr];
  assign count_o       = count;
  assign almost_full_o = (count >= AF_COUNT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (!active) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_STEP;
      if (pop)  rd_ptr <= rd_ptr + PTR_STEP;
      case ({push, pop})
        2'b10:   count <= count + COUNT_STEP;
        2'b01:   count <= count - COUNT_STEP;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only observable once count covers it,
  // so clearing the array would add reset fan-out without changing behaviour.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: tb/tb_depth_fifo.sv
// Bench for depth_fifo: directed scenarios with literal expectations plus a queue-based
// reference model compared against every output on each falling clock edge.
module tb_depth_fifo;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  logic             clk_i     = 1'b0;
  logic             reset_n_i = 1'b0;
  logic             flush_i   = 1'b0;
  logic             valid_i   = 1'b0;
  logic [WIDTH-1:0] data_i    = '0;
  logic             ready_i   = 1'b0;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic [2:0]       count_o;
  logic             almost_full_o;

  always #5 clk_i = ~clk_i;

  depth_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .data_i        (data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a plain queue updated from the handshake rules at each rising edge.
  always @(posedge clk_i) begin : model_update
    bit m_ready;
    bit m_push;
    bit m_pop;
    m_ready = reset_n_i && !flush_i && (model_q.size() != DEPTH || ready_i);
    m_push  = valid_i && m_ready;
    m_pop   = reset_n_i && !flush_i && model_q.size() != 0 && ready_i;
    if (!reset_n_i || flush_i) begin
      model_q.delete();
    end else begin
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(data_i);
    end
    live = 1'b1;
  end

  always @(negedge clk_i) begin : compare
    int sz;
    if (live) begin
      sz = model_q.size();
      check("model_count", 32'(count_o), sz);
      check("model_valid", 32'(valid_o), 32'(sz != 0));
      check("model_almost_full", 32'(almost_full_o), 32'(sz >= AF_LEVEL));
      check("model_ready", 32'(ready_o),
            32'(reset_n_i && !flush_i && (sz != DEPTH || ready_i)));
      if (sz != 0) check("model_data", 32'(data_o), 32'(model_q[0]));
    end
  end

  task automatic drive(input logic rn, input logic fl, input logic v,
                       input logic [WIDTH-1:0] d, input logic r);
    reset_n_i = rn;
    flush_i   = fl;
    valid_i   = v;
    data_i    = d;
    ready_i   = r;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill4();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
      tick();
      check("fill_count", 32'(count_o), i + 1);
      check("fill_af", 32'(almost_full_o), 32'(i >= 2));
    end
  endtask

  initial begin
    // Reset state
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check("rst_count", 32'(count_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_ready", 32'(ready_o), 0);
    check("rst_af", 32'(almost_full_o), 0);

    // Fill then drain
    fill4();
    drive(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
    #1;
    check("full_ready", 32'(ready_o), 0);
    check("full_valid", 32'(valid_o), 1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(data_o), 32'(8'h11 * (i + 1)));
      tick();
      check("drain_count", 32'(count_o), 3 - i);
    end
    check("drain_valid", 32'(valid_o), 0);

    // Full pass-through: pop oldest and accept new entry in the same cycle
    fill4();
    drive(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
    #1;
    check("pass_ready", 32'(ready_o), 1);
    check("pass_head", 32'(data_o), 32'h11);
    tick();
    check("pass_count", 32'(count_o), 4);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("pass_order", 32'(data_o), 32'(8'h22 + 8'h11 * i));
      tick();
    end
    check("pass_empty", 32'(count_o), 0);

    // Streaming with continuous ready: one-cycle latency, pointers wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
      tick();
      check("stream_data", 32'(data_o), i);
      check("stream_count", 32'(count_o), 1);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check("stream_empty", 32'(count_o), 0);

    // Flush beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'(8'h61 + i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
    #1;
    check("flush_ready", 32'(ready_o), 0);
    tick();
    check("flush_count", 32'(count_o), 0);
    check("flush_valid", 32'(valid_o), 0);
    drive(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    tick();
    check("flush_next", 32'(data_o), 32'hA5);
    check("flush_next_count", 32'(count_o), 1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();

    // Reset mid-stream discards stored entries
    drive(1'b1, 1'b0, 1'b1, 8'h71, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 8'h72, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
    #1;
    check("mrst_ready", 32'(ready_o), 0);
    tick();
    check("mrst_count", 32'(count_o), 0);
    check("mrst_valid", 32'(valid_o), 0);
    drive(1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 8'h02, 1'b0);
    tick();
    check("mrst_count2", 32'(count_o), 2);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check("mrst_first", 32'(data_o), 32'h01);
    tick();
    check("mrst_second", 32'(data_o), 32'h02);
    tick();
    check("mrst_empty", 32'(count_o), 0);

    // Random backpressure, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 10000; i++) begin
      int  phase;
      logic v;
      logic r;
      phase = (i / 500) % 2;
      v = ($urandom_range(0, 3) < ((phase == 0) ? 3 : 1));
      r = ($urandom_range(0, 3) < ((phase == 0) ? 1 : 3));
      drive(1'b1, 1'b0, v, 8'($urandom), r);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (DEPTH + 1) tick();
    check("final_empty", 32'(count_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
